lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store initiator that sits between the pipeline memory stage and the byte-addressed data `ram`. It accepts one load or store request at a time and performs byte, halfword and word accesses against the RAM's 32-bit port. It presents a little-endian view to the core, while the RAM packs the byte at the lowest address into bits [31:24]. Sub-word stores are done as read-modify-write because the RAM always writes 4 bytes.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width, passed through to the RAM address ports.
- `DATA_W`, 32, data width; the block supports only 32.

Ports:
- `clk` input 1 — single clock; all state updates on the posedge.
- `rst` input 1 — reset, synchronous and active-high.
- `req_valid` input 1 — request present.
- `req_ready` output 1 — request accepted when this and `req_valid` are both 1 on a clock edge.
- `req_we` input 1 — 1 = store, 0 = load.
- `req_size` input 2 — 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_unsigned` input 1 — load zero-extends when 1, sign-extends when 0.
- `req_addr` input ADDR_W — byte address.
- `req_wdata` input DATA_W — store data, right-aligned.
- `resp_valid` output 1 — response present.
- `resp_ready` input 1 — response consumed when this and `resp_valid` are both 1.
- `resp_rdata` output DATA_W — load result; 0 for stores.
- `resp_err` output 1 — request rejected; no memory side effect.
- `mem_r_addr`, `mem_w_addr` output ADDR_W — both driven from the latched address.
- `mem_r_data` input DATA_W — combinational RAM read data, byte A at [31:24].
- `mem_w_data` output DATA_W — RAM write data.
- `mem_we` output 1 — RAM write enable.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- `req_ready` = (state == IDLE) && !`rst`.
- IDLE, on acceptance: latch addr, size, we, unsigned and wdata. Next state:
  - size 3 → RESP with `resp_err` = 1.
  - misaligned, when the trap is enabled → RESP with `resp_err` = 1.
  - word store → WRITE.
  - otherwise → READ.
- READ: `mem_r_addr` = latched addr; capture `mem_r_data` as r.
  - Load → RESP with formatted data.
  - Sub-word store → WRITE with merged data.
- Load formatting:
  - byte = r[31:24].
  - half = {r[23:16], r[31:24]}.
  - word = {r[7:0], r[15:8], r[23:16], r[31:24]}.
  - Byte and half are extended per `req_unsigned`.
- Store data (d = wdata):
  - byte → {d[7:0], r[23:0]}.
  - half → {d[7:0], d[15:8], r[15:0]}.
  - word → {d[7:0], d[15:8], d[23:16], d[31:24]}; no read is performed.
- WRITE: `mem_we` = 1 for exactly this one cycle, with `mem_w_addr` = latched addr. Next state RESP.
- RESP: `resp_valid` = 1 and outputs hold stable until `resp_ready`, then IDLE.
- `resp_err` responses carry `resp_rdata` = 0. `mem_we` is never asserted for an errored request.
- Alignment rules: half is misaligned if addr[0] = 1; word is misaligned if addr[1:0] ≠ 0.

## Timing
- Cycle 0 is the acceptance edge.
- `resp_valid` rises at:
  - load: cycle 2.
  - word store: cycle 2, with `mem_we` high in cycle 1.
  - sub-word store: cycle 3, with the read in cycle 1 and `mem_we` high in cycle 2.
  - error: cycle 1.
- Throughput: one request in flight. The next acceptance happens no earlier than the cycle after the response handshake.
- Reset values, and values while `rst` = 1:
  - state IDLE.
  - `req_ready` 0, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0.
  - `mem_we` 0, `mem_r_addr` 0, `mem_w_addr` 0, `mem_w_data` 0.
- Reset mid-operation: the pending access is abandoned. `mem_we` is gated by !`rst`, so a write scheduled in the reset cycle does not occur. No response is issued.
- `resp_ready` held low stalls indefinitely in RESP with no further memory activity.
- `resp_ready` asserted outside RESP is ignored.
- The read-modify-write is not atomic against other RAM writers; this block must be the sole writer.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned half and word requests return `resp_err` = 1 at cycle 1 with no RAM access.
- `LSU_MISALIGN_TRAP_EN` undefined: misaligned requests proceed exactly as aligned ones, since the RAM port accepts any byte address. `resp_err` is then set only for size 3.

## Test plan
- Word store 0x11223344 @0x100, then word load @0x100 → RAM bytes [0x100..0x103] = 44,33,22,11; `resp_rdata` = 0x11223344 at cycle 2 of the load.
- Memory word 0x11223344 @0x100, byte store 0xAB @0x102 → exactly one `mem_we` pulse; word load @0x100 returns 0x11AB3344.
- Byte load @0x103 of 0x80..., signed → 0xFFFFFF80 (byte 0x80 at 0x103); unsigned → 0x00000080. Half load @0x100 of bytes 0x00,0x80 signed → 0xFFFF8000.
- Trap enabled: word load @0x101 → `resp_err` = 1 at cycle 1, `mem_we` never high. Trap disabled: the same load returns the little-endian bytes 0x101..0x104. `req_size` = 3 → `resp_err` in both builds.
- `resp_ready` held low for 5 cycles → `resp_valid`/`resp_rdata` stable and `req_ready` = 0; release → IDLE next cycle.
- Assert `rst` during WRITE of a sub-word store → no RAM write, all outputs 0. First request after deassertion completes normally.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store initiator: little-endian core view over a RAM packing the lowest-address byte in [31:24].
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word requests with resp_err.
module lsu_mem_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [ADDR_W-1:0] mem_w_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_we
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;

  logic              misaligned;
  logic              req_bad;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif
  assign req_bad = (req_size == 2'd3) || misaligned;

  // Byte A sits at [31:24]; the core expects it in the least significant lane.
  assign ld_b = mem_r_data[31:24];
  assign ld_h = {mem_r_data[23:16], mem_r_data[31:24]};

  always_comb begin
    case (size_q)
      2'd0:    load_data = uns_q ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'd1:    load_data = uns_q ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: load_data = bswap(mem_r_data);
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    merge_data = {wdata_q[7:0], mem_r_data[23:0]};
      2'd1:    merge_data = {wdata_q[7:0], wdata_q[15:8], mem_r_data[15:0]};
      default: merge_data = bswap(wdata_q);
    endcase
  end

  // NOTE: every next-state signal takes its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wbuf_d  = wbuf_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          err_d   = req_bad;
          rdata_d = '0;
          wbuf_d  = bswap(req_wdata);
          if (req_bad)                          state_d = S_RESP;
          else if (req_we && req_size == 2'd2)  state_d = S_WRITE;
          else                                  state_d = S_READ;
        end
      end
      S_READ: begin
        if (we_q) begin
          wbuf_d  = merge_data;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      wbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wbuf_q  <= wbuf_d;
    end
  end

  // Outputs are gated by rst so a write or response scheduled in the reset cycle never escapes.
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_RESP) && !rst;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign mem_we     = (state_q == S_WRITE) && !rst;
  assign mem_r_addr = rst ? '0 : addr_q;
  assign mem_w_addr = rst ? '0 : addr_q;
  assign mem_w_data = rst ? '0 : wbuf_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: byte-level reference memory predicts each response and its timing.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_r_addr, mem_w_addr, mem_r_data, mem_w_data;
  logic        mem_we;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;

  logic [7:0] ram     [0:4095] = '{default: 8'h00};
  logic [7:0] ref_mem [0:4095];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_lat;
  } exp_t;

  exp_t sb[$];

  lsu_mem_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_r_data(mem_r_data),
    .mem_w_data(mem_w_data), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  function automatic int ix(input logic [31:0] a, input int k);
    return int'((a + 32'(k)) & 32'hFFF);
  endfunction

  // RAM: byte at the lowest address on [31:24], combinational read, write on the edge.
  always_comb mem_r_data = {ram[ix(mem_r_addr, 0)], ram[ix(mem_r_addr, 1)],
                            ram[ix(mem_r_addr, 2)], ram[ix(mem_r_addr, 3)]};

  always @(posedge clk) begin
    if (mem_we) begin
      ram[ix(mem_w_addr, 0)] <= mem_w_data[31:24];
      ram[ix(mem_w_addr, 1)] <= mem_w_data[23:16];
      ram[ix(mem_w_addr, 2)] <= mem_w_data[15:8];
      ram[ix(mem_w_addr, 3)] <= mem_w_data[7:0];
      we_cnt <= we_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Little-endian reference: predicts data, error and latencies; applies store side effects.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
    logic bad;
    logic [7:0] b0, b1, b2, b3;
    int n;
    bad = (size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) bad = 1'b1;
`endif
    e.err = bad; e.rdata = '0; e.we_lat = 0;
    if (bad) begin
      e.lat = 1;
    end else if (we) begin
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      for (int k = 0; k < n; k++) ref_mem[ix(addr, k)] = wd[8*k +: 8];
      e.lat    = (size == 2'd2) ? 2 : 3;
      e.we_lat = e.lat - 1;
    end else begin
      b0 = ref_mem[ix(addr, 0)]; b1 = ref_mem[ix(addr, 1)];
      b2 = ref_mem[ix(addr, 2)]; b3 = ref_mem[ix(addr, 3)];
      e.lat = 2;
      case (size)
        2'd0:    e.rdata = uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
        2'd1:    e.rdata = uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
        default: e.rdata = {b3, b2, b1, b0};
      endcase
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int stall);
    exp_t e, got;
    int t, lat, we_lat, we0;
    logic [31:0] snap;
    model(we, size, uns, addr, wd, e);
    sb.push_back(e);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; resp_ready = (stall == 0);
    t = 0;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    n_tests++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL %s accept: req_ready=%b, required 1 within 20 cycles", tag, req_ready);
      void'(sb.pop_back());
      req_valid = 1'b0;
      return;
    end
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; we_lat = 0;
    while (!resp_valid && lat < 20) begin
      if (mem_we && we_lat == 0) we_lat = lat;
      @(posedge clk); #1; lat++;
    end
    got = sb.pop_front();
    n_tests++;
    if (lat !== got.lat) begin
      n_fail++; $display("FAIL %s resp latency: got %0d, required %0d", tag, lat, got.lat);
    end
    n_tests++;
    if (we_lat !== got.we_lat) begin
      n_fail++; $display("FAIL %s mem_we cycle: got %0d, required %0d", tag, we_lat, got.we_lat);
    end
    snap = resp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_rdata !== snap || req_ready !== 1'b0 || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall %0d: valid=%b rdata=%h ready=%b we=%b, required 1 %h 0 0",
                 tag, i, resp_valid, resp_rdata, req_ready, mem_we, snap);
      end
    end
    n_tests++;
    if (resp_rdata !== got.rdata) begin
      n_fail++; $display("FAIL %s rdata: got %h, required %h", tag, resp_rdata, got.rdata);
    end
    n_tests++;
    if (resp_err !== got.err) begin
      n_fail++; $display("FAIL %s err: got %b, required %b", tag, resp_err, got.err);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s return to idle: valid=%b ready=%b, required 0 1", tag, resp_valid, req_ready);
    end
    n_tests++;
    if (we_cnt - we0 !== ((got.we_lat != 0) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s write pulses: got %0d, required %0d", tag, we_cnt - we0, (got.we_lat != 0) ? 1 : 0);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    n_tests++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b0 || resp_rdata !== 32'h0 ||
        mem_r_addr !== 32'h0 || mem_w_addr !== 32'h0 || mem_w_data !== 32'h0) begin
      n_fail++;
      $display("FAIL %s outputs in reset: rdy=%b vld=%b err=%b we=%b rd=%h ra=%h wa=%h wd=%h, required all 0",
               tag, req_ready, resp_valid, resp_err, mem_we, resp_rdata, mem_r_addr, mem_w_addr, mem_w_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'hDEADBEEF; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset release req_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_word_store_load();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    do_req("word_store", 1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, 0);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (ram[ix(32'h100, k)] !== exp_b[k]) begin
        n_fail++; $display("FAIL ram byte %0d: got %h, required %h", k, ram[ix(32'h100, k)], exp_b[k]);
      end
    end
    do_req("word_load", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
  endtask

  task automatic test_subword_store();
    do_req("byte_store", 1'b1, 2'd0, 1'b0, 32'h102, 32'h000000AB, 0);
    do_req("word_after_byte", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
    do_req("half_store", 1'b1, 2'd1, 1'b0, 32'h200, 32'h00008000, 0);
  endtask

  task automatic test_sign_ext();
    do_req("byte_store_80", 1'b1, 2'd0, 1'b0, 32'h103, 32'h00000080, 0);
    do_req("byte_load_s", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0);
    do_req("byte_load_u", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0);
    do_req("half_load_s", 1'b0, 2'd1, 1'b0, 32'h200, 32'h0, 0);
    do_req("half_load_u", 1'b0, 2'd1, 1'b1, 32'h200, 32'h0, 0);
  endtask

  task automatic test_misalign();
    do_req("mis_word_load", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0);
    do_req("mis_half_store", 1'b1, 2'd1, 1'b0, 32'h301, 32'h0000CAFE, 0);
    do_req("mis_half_load", 1'b0, 2'd1, 1'b1, 32'h301, 32'h0, 0);
    do_req("size3_load", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0);
    do_req("size3_store", 1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFFFFFF, 0);
  endtask

  task automatic test_stall();
    do_req("stall_load", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5);
    do_req("stall_store", 1'b1, 2'd0, 1'b0, 32'h104, 32'h0000005A, 5);
  endtask

  task automatic test_reset_mid();
    int we0;
    logic [7:0] b0;
    we0 = we_cnt; b0 = ram[ix(32'h101, 0)];
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h101; req_wdata = 32'h000000EE; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (mem_we !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid write phase: mem_we=%b, required 1", mem_we);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid gated we: mem_we=%b, required 0", mem_we);
    end
    @(posedge clk); #1;
    check_idle_zero("reset_mid");
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      n_tests++;
      if (resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid spurious response: resp_valid=%b, required 0", resp_valid);
      end
    end
    resp_ready = 1'b0;
    n_tests++;
    if (we_cnt !== we0 || ram[ix(32'h101, 0)] !== b0) begin
      n_fail++;
      $display("FAIL reset_mid ram: pulses=%0d byte=%h, required %0d %h", we_cnt, ram[ix(32'h101, 0)], we0, b0);
    end
    do_req("after_reset_load", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'h300 + 32'($urandom_range(0, 63));
      do_req("random", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_sign_ext();
    test_misalign();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
